// File: rtl/uarch_pkg.sv
// Shared micro-architecture types for the memory-side blocks.
// Holds the arbiter FSM states, ownership tags and strobe width.
package uarch_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT_R
    } arb_state_t;

    typedef enum logic {
        OWN_I,
        OWN_D
    } arb_owner_t;

    localparam int MEM_STRB_W = 8;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin picker between icache and dcache.
// Grant is combinational; history advances only on an accept.
module rr_arb2
    import uarch_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       req_i,
    input  logic       req_d,
    input  logic       accept,
    output arb_owner_t grant
);

    arb_owner_t last_grant;

    always_comb begin
        grant = OWN_I;
        if (req_i && req_d) begin
            grant = (last_grant == OWN_I) ? OWN_D : OWN_I;
        end else if (req_d) begin
            grant = OWN_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant <= OWN_I;
        end else if (accept) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one 64-bit memory port between icache and dcache.
// Round-robin, single outstanding transaction, response routed to owner.
module mem_arbiter
    import uarch_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int IDATA_W = 64,
    parameter int DDATA_W = 32,
    parameter int MEM_W   = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     icache_addr,
    input  logic                  icache_re,
    output logic [IDATA_W-1:0]    icache_dout,
    output logic                  icache_dout_val,
    output logic                  icache_stall,
    input  logic [ADDR_W-1:0]     dcache_addr,
    input  logic                  dcache_re,
    input  logic [3:0]            dcache_we,
    input  logic [DDATA_W-1:0]    dcache_din,
    output logic [DDATA_W-1:0]    dcache_dout,
    output logic                  dcache_dout_val,
    output logic                  dcache_stall,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic                  mem_req,
    output logic [MEM_STRB_W-1:0] mem_wstrb,
    output logic [MEM_W-1:0]      mem_wdata,
    input  logic                  mem_gnt,
    input  logic [MEM_W-1:0]      mem_rdata,
    input  logic                  mem_rvalid
);

    arb_state_t            state;
    arb_state_t            state_n;
    arb_owner_t            owner_q;
    arb_owner_t            grant;
    logic [MEM_STRB_W-1:0] strb_q;
    logic                  hi_q;
    logic                  d_req;
    logic                  idle;
    logic                  accept;
    logic                  unused_lsb;

    // A nonzero strobe makes it a store even if dcache_re is also set
    assign d_req  = dcache_re || (dcache_we != 4'b0);
    assign idle   = (state == ARB_IDLE);
    assign accept = idle && (icache_re || d_req);

    assign icache_stall = icache_re && !(idle && grant == OWN_I);
    assign dcache_stall = d_req && !(idle && grant == OWN_D);

    assign mem_req   = (state == ARB_ISSUE);
    assign mem_wstrb = mem_req ? strb_q : '0;

    assign unused_lsb = ^{icache_addr[2:0], dcache_addr[1:0]};

    rr_arb2 u_rr (
        .clk    (clk),
        .rst    (rst),
        .req_i  (icache_re),
        .req_d  (d_req),
        .accept (accept),
        .grant  (grant)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ARB_IDLE: begin
                if (accept) state_n = ARB_ISSUE;
            end
            ARB_ISSUE: begin
                if (mem_gnt) begin
                    state_n = (strb_q != '0) ? ARB_IDLE : ARB_WAIT_R;
                end
            end
            ARB_WAIT_R: begin
                if (mem_rvalid) state_n = ARB_IDLE;
            end
            default: state_n = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q         <= OWN_I;
            mem_addr        <= '0;
            strb_q          <= '0;
            hi_q            <= 1'b0;
            mem_wdata       <= '0;
            icache_dout     <= '0;
            dcache_dout     <= '0;
            icache_dout_val <= 1'b0;
            dcache_dout_val <= 1'b0;
        end else begin
            icache_dout_val <= 1'b0;
            dcache_dout_val <= 1'b0;
            if (accept) begin
                owner_q <= grant;
                if (grant == OWN_I) begin
                    mem_addr <= {icache_addr[ADDR_W-1:3], 3'b000};
                    strb_q   <= '0;
                    hi_q     <= 1'b0;
                end else begin
                    mem_addr  <= {dcache_addr[ADDR_W-1:3], 3'b000};
                    hi_q      <= dcache_addr[2];
                    strb_q    <= dcache_addr[2] ? {dcache_we, 4'b0000}
                                                : {4'b0000, dcache_we};
                    mem_wdata <= {dcache_din, dcache_din};
                end
            end
            // Late responses outside WAIT_R never reach a requester
            if (state == ARB_WAIT_R && mem_rvalid) begin
                if (owner_q == OWN_I) begin
                    icache_dout     <= mem_rdata[IDATA_W-1:0];
                    icache_dout_val <= 1'b1;
                end else begin
                    dcache_dout     <= hi_q ? mem_rdata[MEM_W-1:DDATA_W]
                                            : mem_rdata[DDATA_W-1:0];
                    dcache_dout_val <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter against a transaction-level model.
// Covers arbitration fairness, width mapping, stalls and mid-flight reset.
module tb_mem_arbiter;
    import uarch_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [63:0] icache_dout;
    logic        icache_dout_val;
    logic        icache_stall;
    logic [31:0] dcache_addr;
    logic        dcache_re;
    logic [3:0]  dcache_we;
    logic [31:0] dcache_din;
    logic [31:0] dcache_dout;
    logic        dcache_dout_val;
    logic        dcache_stall;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic [7:0]  mem_wstrb;
    logic [63:0] mem_wdata;
    logic        mem_gnt;
    logic [63:0] mem_rdata;
    logic        mem_rvalid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk             (clk),
        .rst             (rst),
        .icache_addr     (icache_addr),
        .icache_re       (icache_re),
        .icache_dout     (icache_dout),
        .icache_dout_val (icache_dout_val),
        .icache_stall    (icache_stall),
        .dcache_addr     (dcache_addr),
        .dcache_re       (dcache_re),
        .dcache_we       (dcache_we),
        .dcache_din      (dcache_din),
        .dcache_dout     (dcache_dout),
        .dcache_dout_val (dcache_dout_val),
        .dcache_stall    (dcache_stall),
        .mem_addr        (mem_addr),
        .mem_req         (mem_req),
        .mem_wstrb       (mem_wstrb),
        .mem_wdata       (mem_wdata),
        .mem_gnt         (mem_gnt),
        .mem_rdata       (mem_rdata),
        .mem_rvalid      (mem_rvalid)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Pending upstream requests (held until the model says accepted)
    logic        pend_i, pend_d;
    logic [31:0] p_ia, p_da, p_din;
    logic [3:0]  p_we;
    // Outstanding transaction as seen from the memory side
    logic        have_txn, granted, last_d;
    logic        t_own_d, t_store, t_hi;
    logic [31:0] t_addr;
    logic [7:0]  t_strb;
    logic [63:0] t_wdata;
    int          gdly, rdly;
    // Events at the coming clock edge
    logic        acc_i, acc_d, gnt_fire, rv_fire;
    logic [63:0] rv_data;

    task automatic reset_model();
        pend_i = 0; pend_d = 0;
        have_txn = 0; granted = 0; last_d = 0;
        acc_i = 0; acc_d = 0; gnt_fire = 0; rv_fire = 0;
        gdly = 0; rdly = 0;
    endtask

    task automatic drive_idle();
        icache_re = 0; icache_addr = 0;
        dcache_re = 0; dcache_we = 0; dcache_addr = 0; dcache_din = 0;
        mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        drive_idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 64'(mem_req), 0);
        check("rst_wstrb", 64'(mem_wstrb), 0);
        check("rst_addr", 64'(mem_addr), 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_ival", 64'(icache_dout_val), 0);
        check("rst_dval", 64'(dcache_dout_val), 0);
        check("rst_idout", icache_dout, 0);
        check("rst_ddout", 64'(dcache_dout), 0);
        rst = 0;
        reset_model();
    endtask

    task automatic run_random(input int n, input bit tie_first);
        logic        e_iv, e_dv, win_d, idle;
        logic [63:0] e_id;
        logic [31:0] e_dd;
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            e_iv = 0; e_dv = 0; e_id = 0; e_dd = 0;
            if (rv_fire) begin
                if (!t_own_d) begin
                    e_iv = 1; e_id = rv_data;
                end else begin
                    e_dv = 1;
                    e_dd = t_hi ? rv_data[63:32] : rv_data[31:0];
                end
                have_txn = 0;
            end
            if (gnt_fire) begin
                if (t_store) have_txn = 0;
                else begin
                    granted = 1;
                    rdly = $urandom_range(0, 3);
                end
            end
            if (acc_i || acc_d) begin
                have_txn = 1; granted = 0;
                gdly = $urandom_range(0, 6);
                t_own_d = acc_d;
                last_d = acc_d;
                if (acc_i) begin
                    t_addr = p_ia & ~32'h7;
                    t_store = 0; t_strb = 0; t_hi = 0; t_wdata = 0;
                    pend_i = 0;
                end else begin
                    t_addr = p_da & ~32'h7;
                    t_hi = p_da[2];
                    t_store = (p_we != 0);
                    t_strb = t_hi ? 8'(p_we) * 8'd16 : 8'(p_we);
                    t_wdata = {p_din, p_din};
                    pend_d = 0;
                end
            end
            check("ival", 64'(icache_dout_val), 64'(e_iv));
            check("dval", 64'(dcache_dout_val), 64'(e_dv));
            if (e_iv) check("idout", icache_dout, e_id);
            if (e_dv) check("ddout", 64'(dcache_dout), 64'(e_dd));

            if (!pend_i && (tie_first && c == 0 || $urandom_range(0, 2) == 0)) begin
                pend_i = 1;
                p_ia = $urandom & 32'h0000_FFF8;
            end
            if (!pend_d && (tie_first && c == 0 || $urandom_range(0, 2) == 0)) begin
                pend_d = 1;
                p_da = $urandom & 32'h0000_FFFC;
                p_din = $urandom;
                p_we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'b0;
            end
            icache_re = pend_i;
            icache_addr = pend_i ? p_ia : 32'($urandom);
            dcache_re = pend_d && (p_we == 0);
            dcache_we = pend_d ? p_we : 4'b0;
            dcache_addr = p_da;
            dcache_din = p_din;

            mem_gnt = 0;
            mem_rvalid = 0;
            mem_rdata = {$urandom, $urandom};
            if (have_txn && !granted) begin
                mem_gnt = (gdly == 0);
                if (gdly > 0) gdly--;
            end else if (have_txn && granted) begin
                mem_rvalid = (rdly == 0);
                if (rdly > 0) rdly--;
            end else begin
                mem_rvalid = ($urandom_range(0, 7) == 0);
            end
            #1;
            idle = !have_txn;
            win_d = pend_d && (!pend_i || !last_d);
            check("istall", 64'(icache_stall), 64'(pend_i && !(idle && !win_d)));
            check("dstall", 64'(dcache_stall), 64'(pend_d && !(idle && win_d)));
            check("mem_req", 64'(mem_req), 64'(have_txn && !granted));
            if (have_txn && !granted) begin
                check("mem_addr", 64'(mem_addr), 64'(t_addr));
                check("mem_wstrb", 64'(mem_wstrb), 64'(t_strb));
                if (t_store) check("mem_wdata", mem_wdata, t_wdata);
            end
            acc_i = pend_i && idle && !win_d;
            acc_d = pend_d && idle && win_d;
            gnt_fire = have_txn && !granted && mem_gnt;
            rv_fire = have_txn && granted && mem_rvalid;
            rv_data = mem_rdata;
        end
    endtask

    initial begin
        do_reset();
        run_random(3000, 1'b1);

        // Reset while waiting for read data, then a stray rvalid
        do_reset();
        @(posedge clk); #1;
        icache_re = 1; icache_addr = 32'h100;
        #1;
        check("dir_acc_stall", 64'(icache_stall), 0);
        @(posedge clk); #1;
        icache_re = 0; mem_gnt = 1;
        #1;
        check("dir_req", 64'(mem_req), 1);
        check("dir_addr", 64'(mem_addr), 64'h100);
        @(posedge clk); #1;
        mem_gnt = 0; rst = 1;
        @(posedge clk); #1;
        rst = 0; mem_rvalid = 1; mem_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        #1;
        check("dir_rst_req", 64'(mem_req), 0);
        check("dir_rst_addr", 64'(mem_addr), 0);
        check("dir_rst_ival", 64'(icache_dout_val), 0);
        check("dir_rst_idout", icache_dout, 0);
        @(posedge clk); #1;
        mem_rvalid = 0;
        #1;
        check("dir_late_ival", 64'(icache_dout_val), 0);
        check("dir_late_dval", 64'(dcache_dout_val), 0);
        reset_model();
        run_random(500, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one downstream memory port between the core's instruction-fetch (icache) and data (dcache) request ports.
- Instantiated in the cpu top between core and memory model.
- Round-robin arbitration; one outstanding transaction at a time.
- Captures the granted request, sequences it to memory, then routes the response back to the owning requester.

Parameters:
- ADDR_W, 32, byte address width on all ports.
- IDATA_W, 64, icache read data width (two instructions per fetch).
- DDATA_W, 32, dcache read/write data width.
- MEM_W, 64, downstream data width; fixed at 64, dword-aligned.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- icache_addr  in  ADDR_W  fetch address, 8B aligned
- icache_re  in  1  fetch request
- icache_dout  out  IDATA_W  fetch data
- icache_dout_val  out  1  fetch data valid, 1-cycle pulse
- icache_stall  out  1  request not accepted this cycle
- dcache_addr  in  ADDR_W  data address, 4B aligned
- dcache_re  in  1  load request
- dcache_we  in  4  store byte strobes; nonzero means store
- dcache_din  in  DDATA_W  store data
- dcache_dout  out  DDATA_W  load data
- dcache_dout_val  out  1  load data valid, 1-cycle pulse
- dcache_stall  out  1  request not accepted this cycle
- mem_addr  out  ADDR_W  downstream address, addr[2:0]=0
- mem_req  out  1  downstream request valid
- mem_wstrb  out  8  downstream byte strobes; 0 means read
- mem_wdata  out  MEM_W  downstream write data
- mem_gnt  in  1  downstream accepts request this cycle
- mem_rdata  in  MEM_W  downstream read data
- mem_rvalid  in  1  downstream read data valid

Behaviour:

Upstream handshake:
- A request is accepted in a cycle when it is asserted and its stall is 0.
- Requester holds addr/data/strobes stable while stalled.
- stall is combinational: stall = request && !(state==IDLE && grant==this port).
- dcache_re together with nonzero dcache_we is illegal; stores take precedence.

Arbitration (IDLE only):
- One requester active: it wins.
- Both active: the port not granted last wins.
- last_grant resets to ICACHE, so dcache wins the first tie.

FSM states, IDLE, ISSUE, WAIT_R:
- IDLE: on acceptance, register addr (with [2:0] cleared), owner, strobes and data; go to ISSUE.
- ISSUE: mem_req=1 with registered fields. When mem_gnt=1: a write goes to IDLE; a read goes to WAIT_R.
- WAIT_R: on mem_rvalid, pulse the owner's dout_val for exactly one cycle, with dout valid that cycle; go to IDLE.
- The upstream port cannot re-accept before the pulse cycle's return to IDLE, so the minimum read turnaround is 3 cycles when gnt and rvalid arrive immediately.
- mem_rvalid outside WAIT_R is ignored.
- mem_gnt in the same cycle as mem_rvalid is impossible by protocol.

Width rules:
- icache_dout = mem_rdata.
- dcache_dout = addr[2] ? mem_rdata[63:32] : mem_rdata[31:0], using the registered address.
- Stores: mem_wstrb = addr[2] ? {we,4'b0} : {4'b0,we}; mem_wdata = {din,din}.
- Store completion gives no dout_val pulse.

Reset:
- Outputs: state IDLE, last_grant ICACHE; mem_req, mem_wstrb, both dout_val 0; mem_addr, mem_wdata, both dout 0.
- Reset mid-transaction abandons it; no response is delivered, and a late mem_rvalid is ignored because state is IDLE.

Decomposition:
- uarch_pkg gains:
  - typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT_R} arb_state_t.
  - typedef enum logic {OWN_I, OWN_D} arb_owner_t.
  - localparam MEM_STRB_W = 8.
- Optional sub-module rr_arb2: 2-input round-robin picker, with combinational grant and a last_grant update on accept.
- Everything else stays in one module.

Test Plan:
1. icache_re=1, addr 0x100; mem_gnt immediate; mem_rvalid one cycle later with rdata 0xDEADBEEF_CAFEF00D -> icache_stall=0 in the accept cycle; mem_req=1 with mem_addr 0x100 the next cycle; icache_dout_val pulses once with that data 3 cycles after accept.
2. dcache_re addr 0x204, rdata 0x11112222_33334444 -> dcache_dout=0x11112222. Repeat at addr 0x200 -> 0x33334444.
3. dcache_we=4'b0011, din 0xAABBCCDD, addr 0x304 -> mem_addr 0x300, mem_wstrb 8'b0011_0000, mem_wdata 0xAABBCCDD_AABBCCDD; state back to IDLE after gnt; no dout_val.
4. Both requesting continuously from reset -> grants alternate D,I,D,I; the loser's stall stays high until its turn.
5. mem_gnt held low for 5 cycles in ISSUE -> mem_req and its fields stay stable; both stalls stay high for new requests.
6. rst asserted in WAIT_R, then mem_rvalid one cycle later -> no dout_val pulse; all outputs at reset values; the next request is serviced normally.
